display_scan: RTL and testbench
===============================

# display_scan

Multiplexed 8-digit 7-segment scan driver for the calculator display path. Sits directly downstream of `display`: captures the number/code request it forwards (`num`, `dp`, `mode`, `codes`) on `latch`, then time-multiplexes the eight digits onto shared active-low segment lines and per-digit active-low anodes. Applies leading-zero blanking, decimal-point placement, anti-ghosting blanking and a frame-complete pulse.

## Interface
- `PRESCALE`, 1000: clock cycles per digit slot; minimum 4.
- `BLANK`, 2: cycles at the start of each slot with all anodes off; must be less than `PRESCALE`.
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `latch` in 1: when high at a clock edge, capture `mode`, `dp`, `codes` and `num` into the shadow registers.
- `mode` in 1: 0 selects number display; 1 selects code display.
- `dp` in 3: decimal-point digit index; 7 = MSD, 0 = LSD.
- `codes` in 4: code selector, used when `mode`=1.
- `num` in 32: 8 BCD nibbles; `num[3:0]` is digit 0 (LSD).
- `an` out 8: anode enables, active-low; `an[i]` drives digit i.
- `seg` out 7: `{g,f,e,d,c,b,a}`, active-low.
- `seg_dp` out 1: decimal-point segment, active-low.
- `frame` out 1: one-cycle pulse each time digit 7's slot ends.

## Operation
- Shadow registers are loaded when `latch`=1. Scanning always uses shadow values, never the live inputs. `latch` held high reloads on every edge.
- Scan state:
  - `cnt` counts 0..PRESCALE-1 and wraps.
  - `idx` counts 0..7 and increments when `cnt`=PRESCALE-1; it wraps 7→0.
  - `frame`=1 for the cycle after the edge where `cnt`=PRESCALE-1 and `idx`=7.
- Anodes: `an` is all ones while `cnt` < BLANK. Otherwise only `an[idx]`=0.
- Number mode, nibble glyph map:
  - 0..9: standard glyphs. Examples: 0=1000000, 1=1111001, 8=0000000.
  - 4'hA: minus (0111111).
  - 4'hB..4'hF: blank (1111111).
- Leading-zero blanking, number mode:
  - Let H = index of the highest nonzero nibble (0 if all nibbles are zero).
  - Digit i is blanked if i > max(H, dp).
  - Digit 0 and the `dp` digit are never blanked.
  - `seg_dp`=0 only on digit `dp`.
- Code mode, `seg_dp`=1 always:
  - 4'h0: all digits blank.
  - 4'h1: digit 2 = "E" (0000110), digits 1 and 0 = "r" (0101111), all others blank.
  - 4'h2: all digits show minus.
  - 4'h3..4'hF: all digits blank.
- The scan does not restart on `latch`. New content takes effect mid-slot.
- Reset, asynchronous:
  - Outputs: `an`=8'hFF, `seg`=7'h7F, `seg_dp`=1, `frame`=0.
  - Counters: `cnt`=0, `idx`=0.
  - Shadow registers: `num`=0, `dp`=0, `mode`=0, `codes`=0.
  - After release, the display shows a single "0" on digit 0.

## Timing
- All outputs are registered. Outputs in cycle k reflect `cnt`, `idx` and shadow values from cycle k-1.
- Latch-to-display latency: a latch at edge N updates the shadows at N. `seg`/`seg_dp` reflect the new data from edge N+1 whenever the active digit is on.
- Slot length is exactly PRESCALE cycles. The frame period is 8·PRESCALE cycles.
- `an` is low for exactly PRESCALE-BLANK consecutive cycles per slot.
- `seg` is don't-care while `an`=8'hFF, but must not glitch to a different digit's glyph while that digit's anode is low.
- Reset asserted mid-slot forces reset values immediately, without waiting for a clock. Scanning restarts from `idx`=0, `cnt`=0 on the first edge after release.
- `latch` coincident with a slot boundary: the new shadows and the new `idx` are both used from the next cycle.

## Test plan
All scenarios use PRESCALE=8 and BLANK=2.
- Reset release, no latch:
  - Digit 0 slot shows `seg`=1000000 with `seg_dp`=0 (dp=0).
  - Digits 1..7 are blank.
  - `an` pattern in slot 0 is 2 cycles of FF, then 6 cycles of FE.
  - `frame` pulses once every 64 cycles.
- Latch `num`=32'h00012345, `dp`=2, `mode`=0:
  - Digits 4..0 show 1,2,3,4,5; digits 7..5 are blank.
  - `seg_dp`=0 only during digit 2.
- Latch `num`=0, `dp`=5:
  - Digits 5..0 show 0 and digits 7..6 are blank.
  - Decimal point appears on digit 5.
- Latch `num`=32'h0000A007 (minus, then 7), `dp`=0:
  - Digit 3 shows minus (0111111), digits 2..1 show 0, digit 0 shows 7.
  - Digits above 3 are blank.
- Code mode, `codes`=1:
  - Digit 2 shows E, digits 1..0 show r, all others blank, `seg_dp`=1 everywhere.
  - Then latch `codes`=2 mid-slot 5: the new minus glyph appears on the next cycle and `idx` is unaffected.
- Assert `reset` mid-slot 3: `an`=FF and `seg`=7F without a clock edge. After release, the shadows are cleared and the scan restarts at slot 0.

Source files
------------

// File: rtl/display_scan.sv
// display_scan: multiplexed 8-digit active-low 7-segment scan driver.
// Shadows the number/code request on latch, then walks the digits with a
// per-slot anode blanking window and a one-cycle frame pulse per full scan.
module display_scan #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        latch_i,
    input  logic        mode_i,
    input  logic [2:0]  dp_i,
    input  logic [3:0]  codes_i,
    input  logic [31:0] num_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        seg_dp_o,
    output logic        frame_o
);

    localparam int unsigned CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [6:0]  SEG_OFF = 7'h7F;
    localparam logic [6:0]  SEG_MIN = 7'h3F;
    localparam logic [6:0]  SEG_E   = 7'h06;
    localparam logic [6:0]  SEG_R   = 7'h2F;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             mode_q;
    logic [2:0]       dp_q;
    logic [3:0]       codes_q;
    logic [31:0]      num_q;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             seg_dp_q, seg_dp_d;
    logic             frame_q, frame_d;

    logic             cnt_last;
    logic [3:0]       nib;
    logic [2:0]       high_idx;
    logic [2:0]       limit;

    // Nibble to active-low glyph {g,f,e,d,c,b,a}; 0xA is minus, 0xB..0xF blank.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h10;
            4'hA:    glyph = SEG_MIN;
            default: glyph = SEG_OFF;
        endcase
    endfunction

    // Next scan position and next registered outputs from the current state.
    always_comb begin
        cnt_last = (cnt_q == CNT_W'(PRESCALE - 1));
        cnt_d    = cnt_last ? '0 : cnt_q + CNT_W'(1);
        idx_d    = cnt_last ? idx_q + 3'd1 : idx_q;
        frame_d  = cnt_last && (idx_q == 3'd7);
        an_d     = (cnt_q < CNT_W'(BLANK)) ? 8'hFF : ~(8'b1 << idx_q);
        seg_d    = SEG_OFF;
        seg_dp_d = 1'b1;
        nib      = num_q[{idx_q, 2'b00} +: 4];
        high_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (num_q[i*4 +: 4] != 4'h0) high_idx = 3'(i);
        end
        limit = (high_idx > dp_q) ? high_idx : dp_q;

        if (!mode_q) begin
            if (idx_q <= limit) seg_d = glyph(nib);
            if (idx_q == dp_q)  seg_dp_d = 1'b0;
        end else begin
            case (codes_q)
                4'h1: begin
                    if (idx_q == 3'd2)     seg_d = SEG_E;
                    else if (idx_q < 3'd2) seg_d = SEG_R;
                end
                4'h2:    seg_d = SEG_MIN;
                default: seg_d = SEG_OFF;
            endcase
        end
    end

    // Scan counters and request shadows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            mode_q  <= 1'b0;
            dp_q    <= 3'd0;
            codes_q <= 4'h0;
            num_q   <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (latch_i) begin
                mode_q  <= mode_i;
                dp_q    <= dp_i;
                codes_q <= codes_i;
                num_q   <= num_i;
            end
        end
    end

    // Registered display outputs, all derived from the same scan position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_q     <= 8'hFF;
            seg_q    <= SEG_OFF;
            seg_dp_q <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            an_q     <= an_d;
            seg_q    <= seg_d;
            seg_dp_q <= seg_dp_d;
            frame_q  <= frame_d;
        end
    end

    assign an_o     = an_q;
    assign seg_o    = seg_q;
    assign seg_dp_o = seg_dp_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with PRESCALE=8, BLANK=2.
module tb_display_scan;

    logic        clk;
    logic        rst_n;
    logic        latch;
    logic        mode;
    logic [2:0]  dp;
    logic [3:0]  codes;
    logic [31:0] num;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame;

    int checks;
    int errors;
    int ecount;

    logic [6:0] cap_seg[8];
    logic       cap_dp[8];
    logic [7:0] cap_an[8];

    display_scan #(.PRESCALE(8), .BLANK(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .latch_i  (latch),
        .mode_i   (mode),
        .dp_i     (dp),
        .codes_i  (codes),
        .num_i    (num),
        .an_o     (an),
        .seg_o    (seg),
        .seg_dp_o (seg_dp),
        .frame_o  (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; after edge e the outputs show cnt=(e-1)%8, idx=((e-1)/8)%8.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Advance (at least one cycle) until the outputs show frame position pos (0..63).
    task automatic wait_pos(input int pos);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(ecount >= 1 && ((ecount - 1) % 64) == pos) && n < 200);
        if (!(ecount >= 1 && ((ecount - 1) % 64) == pos)) begin
            errors++;
            $display("FAIL wait_pos: position %0d not reached, ecount=%0d", pos, ecount);
        end
    endtask

    // Sample every digit mid-slot (cnt=4) over one frame.
    task automatic capture_frame();
        wait_pos(4);
        for (int d = 0; d < 8; d++) begin
            cap_seg[d] = seg;
            cap_dp[d]  = seg_dp;
            cap_an[d]  = an;
            if (d < 7) repeat (8) step();
        end
    endtask

    task automatic do_latch(input logic m, input logic [2:0] p, input logic [3:0] c,
                            input logic [31:0] n);
        mode = m; dp = p; codes = c; num = n; latch = 1'b1;
        step();
        latch = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: an=%h seg=%h dp=%b frame=%b, want FF 7F 1 0",
                     an, seg, seg_dp, frame);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (an !== ((e <= 2) ? 8'hFF : 8'hFE)) begin
                errors++;
                $display("FAIL slot0_an edge %0d: got %h want %h", e, an,
                         (e <= 2) ? 8'hFF : 8'hFE);
            end
            if (e >= 3) begin
                checks++;
                if (seg !== 7'h40 || seg_dp !== 1'b0) begin
                    errors++;
                    $display("FAIL slot0_zero edge %0d: seg=%b dp=%b want 1000000 0",
                             e, seg, seg_dp);
                end
            end
        end
        capture_frame();
        for (int d = 1; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== 7'h7F || cap_dp[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_blank digit %0d: seg=%b dp=%b want 1111111 1",
                         d, cap_seg[d], cap_dp[d]);
            end
        end
    endtask

    task automatic test_frame_pulse();
        int pulses;
        pulses = 0;
        for (int k = 0; k < 140; k++) begin
            step();
            if (frame === 1'b1) pulses++;
            checks++;
            if (frame !== ((ecount % 64) == 0)) begin
                errors++;
                $display("FAIL frame_pos ecount %0d: got %b want %b", ecount, frame,
                         (ecount % 64) == 0);
            end
        end
        checks++;
        if (pulses < 2 || pulses > 3) begin
            errors++;
            $display("FAIL frame_count: got %0d pulses in 140 cycles, want 2..3", pulses);
        end
    endtask

    task automatic test_number();
        logic [6:0] exp_seg[8];
        exp_seg = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F};
        do_latch(1'b0, 3'd2, 4'h0, 32'h0001_2345);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== (d != 2) ||
                cap_an[d] !== ~(8'b1 << d)) begin
                errors++;
                $display("FAIL number digit %0d: seg=%b dp=%b an=%h want %b %b %h", d,
                         cap_seg[d], cap_dp[d], cap_an[d], exp_seg[d], d != 2, ~(8'b1 << d));
            end
        end
    endtask

    task automatic test_zero_dp();
        do_latch(1'b0, 3'd5, 4'h0, 32'h0);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== ((d <= 5) ? 7'h40 : 7'h7F) || cap_dp[d] !== (d != 5)) begin
                errors++;
                $display("FAIL zero_dp digit %0d: seg=%b dp=%b want %b %b", d, cap_seg[d],
                         cap_dp[d], (d <= 5) ? 7'h40 : 7'h7F, d != 5);
            end
        end
    endtask

    task automatic test_minus();
        logic [6:0] exp_seg[8];
        exp_seg = '{7'h78, 7'h40, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        do_latch(1'b0, 3'd0, 4'h0, 32'h0000_A007);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== (d != 0)) begin
                errors++;
                $display("FAIL minus digit %0d: seg=%b dp=%b want %b %b", d, cap_seg[d],
                         cap_dp[d], exp_seg[d], d != 0);
            end
        end
    endtask

    task automatic test_code();
        logic [6:0] exp_seg[8];
        exp_seg = '{7'h2F, 7'h2F, 7'h06, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        do_latch(1'b1, 3'd3, 4'h1, 32'h8888_8888);
        capture_frame();
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1) begin
                errors++;
                $display("FAIL code_err digit %0d: seg=%b dp=%b want %b 1", d, cap_seg[d],
                         cap_dp[d], exp_seg[d]);
            end
        end
        // Mid-slot 5 switch to code 2.
        wait_pos(5 * 8 + 4);
        checks++;
        if (seg !== 7'h7F || an !== 8'hDF) begin
            errors++;
            $display("FAIL code_pre seg=%b an=%h want 1111111 DF", seg, an);
        end
        do_latch(1'b1, 3'd3, 4'h2, 32'h8888_8888);
        step();
        checks++;
        if (seg !== 7'h3F || an !== 8'hDF || seg_dp !== 1'b1) begin
            errors++;
            $display("FAIL code_switch seg=%b an=%h dp=%b want 0111111 DF 1", seg, an, seg_dp);
        end
        wait_pos(6 * 8 + 4);
        checks++;
        if (seg !== 7'h3F || an !== 8'hBF) begin
            errors++;
            $display("FAIL code_next_slot seg=%b an=%h want 0111111 BF", seg, an);
        end
    endtask

    task automatic test_reset_mid();
        do_latch(1'b0, 3'd1, 4'h0, 32'h8765_4321);
        wait_pos(3 * 8 + 4);
        checks++;
        if (an !== 8'hF7) begin
            errors++;
            $display("FAIL pre_reset an=%h want F7", an);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || seg_dp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: an=%h seg=%h dp=%b frame=%b want FF 7F 1 0",
                     an, seg, seg_dp, frame);
        end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (an !== 8'hFE || seg !== 7'h40 || seg_dp !== 1'b0) begin
            errors++;
            $display("FAIL restart_slot0: an=%h seg=%b dp=%b want FE 1000000 0", an, seg, seg_dp);
        end
        capture_frame();
        for (int d = 1; d < 8; d++) begin
            checks++;
            if (cap_seg[d] !== 7'h7F || cap_dp[d] !== 1'b1) begin
                errors++;
                $display("FAIL cleared digit %0d: seg=%b dp=%b want 1111111 1",
                         d, cap_seg[d], cap_dp[d]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        latch  = 1'b0;
        mode   = 1'b0;
        dp     = 3'd0;
        codes  = 4'h0;
        num    = 32'h0;
        test_reset();
        test_frame_pulse();
        test_number();
        test_zero_dp();
        test_minus();
        test_code();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
